// File: rtl/cpu_ctrl_fsm_if.sv
// cpu_ctrl_fsm_if: IFU and LSU request/response handshake bundle
interface cpu_ctrl_fsm_if;
  logic ifu_reqValid, ifu_respValid, ifu_respErr;
  logic lsu_reqValid, lsu_wen, lsu_respValid, lsu_respErr;
  modport master (
    output ifu_reqValid, lsu_reqValid, lsu_wen,
    input  ifu_respValid, ifu_respErr, lsu_respValid, lsu_respErr
  );
  modport slave (
    input  ifu_reqValid, lsu_reqValid, lsu_wen,
    output ifu_respValid, ifu_respErr, lsu_respValid, lsu_respErr
  );
endinterface

// File: rtl/cpu_ctrl_fsm.sv
// cpu_ctrl_fsm: multi-cycle fetch/load/store/exec sequencer with traps, wait timeout, debug halt and retire count
module cpu_ctrl_fsm #(
  parameter int TIMEOUT_W = 8,
  parameter int TIMEOUT = 200,
  parameter int RETIRE_W = 32
) (
  input  logic                clock,
  input  logic                reset_n,
  cpu_ctrl_fsm_if.master      mem,
  input  logic                dec_load,
  input  logic                dec_store,
  input  logic                dec_branch,
  input  logic                dec_ebreak,
  input  logic                dec_multi,
  input  logic                exec_done,
  input  logic                halt_req,
  output logic                reg_wen,
  output logic                pc_wen,
  output logic                exec_start,
  output logic                finished,
  output logic                ebreak,
  output logic                trap,
  output logic [1:0]          trap_cause,
  output logic [RETIRE_W-1:0] retired,
  output logic [2:0]          state
);
  typedef enum logic [2:0] {START, FETCH, LOAD, STORE, EXEC_MC, EXEC, TRAP, HALT} state_t;
  localparam logic [TIMEOUT_W-1:0] LIMIT = TIMEOUT_W'(TIMEOUT - 1);
  state_t cur, nxt;
  logic ifu_inflight, lsu_inflight, ifu_acc, lsu_acc, timeout, waiting, brk;
  logic ifu_req, lsu_req, lsu_st, reg_w, pc_w, ex_st;
  logic [1:0] cause;
  logic [TIMEOUT_W-1:0] wait_cnt;
  // A response only counts when its unit has a request outstanding; stale ones are dropped
  assign ifu_acc = mem.ifu_respValid & ifu_inflight;
  assign lsu_acc = mem.lsu_respValid & lsu_inflight;
  assign timeout = (TIMEOUT != 0) && (wait_cnt == LIMIT);
  assign waiting = cur == FETCH || cur == LOAD || cur == STORE;
  // Strobes are forced low while reset is held so nothing leaks out of START
  assign mem.ifu_reqValid = reset_n & ifu_req;
  assign mem.lsu_reqValid = reset_n & lsu_req;
  assign mem.lsu_wen = reset_n & lsu_st;
  assign reg_wen = reset_n & reg_w;
  assign pc_wen = reset_n & pc_w;
  assign exec_start = reset_n & ex_st;
  assign state = cur;
  // Next state and strobes; an accepted response beats a timeout, an error beats the decoded class
  always_comb begin
    nxt = cur;
    ifu_req = 1'b0;
    lsu_req = 1'b0;
    lsu_st = 1'b0;
    reg_w = 1'b0;
    pc_w = 1'b0;
    ex_st = 1'b0;
    brk = 1'b0;
    cause = 2'd0;
    case (cur)
      START: begin
        ifu_req = 1'b1;
        nxt = FETCH;
      end
      FETCH: begin
        ifu_req = !ifu_acc;
        if (ifu_acc) begin
          if (mem.ifu_respErr) begin
            nxt = TRAP;
            cause = 2'd1;
          end else if (dec_load) begin
            lsu_req = 1'b1;
            nxt = LOAD;
          end else if (dec_store) begin
            lsu_req = 1'b1;
            lsu_st = 1'b1;
            nxt = STORE;
          end else if (dec_multi) begin
            ex_st = 1'b1;
            nxt = EXEC_MC;
          end else if (dec_ebreak) begin
            brk = 1'b1;
            nxt = HALT;
          end else begin
            reg_w = !dec_branch;
            pc_w = 1'b1;
            nxt = EXEC;
          end
        end else if (timeout) begin
          nxt = TRAP;
          cause = 2'd3;
        end
      end
      LOAD: begin
        lsu_req = !lsu_acc;
        if (lsu_acc) begin
          nxt = mem.lsu_respErr ? TRAP : EXEC;
          cause = mem.lsu_respErr ? 2'd2 : 2'd0;
          reg_w = !mem.lsu_respErr;
          pc_w = !mem.lsu_respErr;
        end else if (timeout) begin
          nxt = TRAP;
          cause = 2'd3;
        end
      end
      STORE: begin
        lsu_req = !lsu_acc;
        lsu_st = !lsu_acc;
        if (lsu_acc) begin
          nxt = mem.lsu_respErr ? TRAP : EXEC;
          cause = mem.lsu_respErr ? 2'd2 : 2'd0;
          pc_w = !mem.lsu_respErr;
        end else if (timeout) begin
          nxt = TRAP;
          cause = 2'd3;
        end
      end
      EXEC_MC: begin
        reg_w = exec_done;
        pc_w = exec_done;
        nxt = exec_done ? EXEC : EXEC_MC;
      end
      EXEC: begin
        ifu_req = !halt_req;
        nxt = halt_req ? HALT : FETCH;
      end
      TRAP: nxt = HALT;
      default: nxt = HALT;
    endcase
  end
  // State, inflight tracking, wait counter, sticky flags and retire bookkeeping
  always_ff @(posedge clock or negedge reset_n) begin
    if (!reset_n) begin
      cur <= START;
      finished <= 1'b0;
      ebreak <= 1'b0;
      trap <= 1'b0;
      trap_cause <= 2'd0;
      retired <= '0;
      ifu_inflight <= 1'b0;
      lsu_inflight <= 1'b0;
      wait_cnt <= '0;
    end else begin
      cur <= nxt;
      finished <= cur == EXEC;
      retired <= retired + RETIRE_W'(cur == EXEC);
      ifu_inflight <= ifu_req | (ifu_inflight & ~ifu_acc);
      lsu_inflight <= lsu_req | (lsu_inflight & ~lsu_acc);
      wait_cnt <= (waiting && nxt == cur) ? wait_cnt + TIMEOUT_W'(1) : '0;
      ebreak <= ebreak | brk;
      if (cause != 2'd0 && !trap) begin
        trap <= 1'b1;
        trap_cause <= cause;
      end
    end
  end
endmodule

// File: tb/tb_cpu_ctrl_fsm.sv
// tb_cpu_ctrl_fsm: directed and random stimulus against a cycle-level behavioural model
module tb_cpu_ctrl_fsm;
  localparam int TW = 8, TO = 6, RW = 4;
  localparam int S_START = 0, S_FETCH = 1, S_LOAD = 2, S_STORE = 3, S_MC = 4, S_EXEC = 5, S_TRAP = 6, S_HALT = 7;
  logic clock = 1'b0, reset_n = 1'b0;
  logic dec_load, dec_store, dec_branch, dec_ebreak, dec_multi, exec_done, halt_req;
  logic reg_wen, pc_wen, exec_start, finished, ebreak, trap;
  logic [1:0] trap_cause;
  logic [RW-1:0] retired;
  logic [2:0] state;
  int checks = 0, errors = 0, cyc = 0;
  int ph = S_START, wait_from = 0, m_cause = 0, m_ret = 0, np, cz, wen_n, pc_n, es_n, r;
  bit m_iout, m_lout, m_fin, m_brk, m_trap, ia, la, to, brk;
  bit e_ir, e_lr, e_lw, e_rw, e_pw, e_es;

  cpu_ctrl_fsm_if bus();

  cpu_ctrl_fsm #(.TIMEOUT_W(TW), .TIMEOUT(TO), .RETIRE_W(RW)) dut (
    .clock(clock), .reset_n(reset_n), .mem(bus),
    .dec_load(dec_load), .dec_store(dec_store), .dec_branch(dec_branch),
    .dec_ebreak(dec_ebreak), .dec_multi(dec_multi), .exec_done(exec_done), .halt_req(halt_req),
    .reg_wen(reg_wen), .pc_wen(pc_wen), .exec_start(exec_start), .finished(finished),
    .ebreak(ebreak), .trap(trap), .trap_cause(trap_cause), .retired(retired), .state(state)
  );

  always #5 clock = ~clock;

  task automatic chk(input string n, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s cycle %0d got %0h want %0h", n, cyc, act, exp);
    end
  endtask

  // Model: each negedge predicts every output from the rules, then advances to the next cycle
  always @(negedge clock) begin
    cyc++;
    {e_ir, e_lr, e_lw, e_rw, e_pw, e_es, brk} = '0;
    np = ph;
    cz = 0;
    if (!reset_n) begin
      ph = S_START;
      {m_iout, m_lout, m_fin, m_brk, m_trap} = '0;
      m_cause = 0;
      m_ret = 0;
      np = S_START;
    end else begin
      ia = bus.ifu_respValid && m_iout;
      la = bus.lsu_respValid && m_lout;
      to = (TO != 0) && (cyc - wait_from == TO - 1);
      case (ph)
        S_START: begin e_ir = 1; np = S_FETCH; end
        S_FETCH:
          if (!ia) begin
            e_ir = 1;
            if (to) begin np = S_TRAP; cz = 3; end
          end else if (bus.ifu_respErr) begin np = S_TRAP; cz = 1; end
          else if (dec_load) begin e_lr = 1; np = S_LOAD; end
          else if (dec_store) begin e_lr = 1; e_lw = 1; np = S_STORE; end
          else if (dec_multi) begin e_es = 1; np = S_MC; end
          else if (dec_ebreak) begin brk = 1; np = S_HALT; end
          else begin e_rw = !dec_branch; e_pw = 1; np = S_EXEC; end
        S_LOAD, S_STORE:
          if (!la) begin
            e_lr = 1;
            e_lw = (ph == S_STORE);
            if (to) begin np = S_TRAP; cz = 3; end
          end else if (bus.lsu_respErr) begin np = S_TRAP; cz = 2; end
          else begin e_rw = (ph == S_LOAD); e_pw = 1; np = S_EXEC; end
        S_MC: if (exec_done) begin e_rw = 1; e_pw = 1; np = S_EXEC; end
        S_EXEC: begin e_ir = !halt_req; np = halt_req ? S_HALT : S_FETCH; end
        S_TRAP: np = S_HALT;
        default: np = S_HALT;
      endcase
    end
    chk("ifu_reqValid", bus.ifu_reqValid, e_ir);
    chk("lsu_reqValid", bus.lsu_reqValid, e_lr);
    chk("lsu_wen", bus.lsu_wen, e_lw);
    chk("reg_wen", reg_wen, e_rw);
    chk("pc_wen", pc_wen, e_pw);
    chk("exec_start", exec_start, e_es);
    chk("finished", finished, m_fin);
    chk("ebreak", ebreak, m_brk);
    chk("trap", trap, m_trap);
    chk("trap_cause", trap_cause, m_cause);
    chk("retired", retired, m_ret);
    chk("state", state, ph);
    if (reset_n) begin
      if (np != ph && (np == S_FETCH || np == S_LOAD || np == S_STORE)) wait_from = cyc + 1;
      m_iout = e_ir || (m_iout && !ia);
      m_lout = e_lr || (m_lout && !la);
      m_fin = (ph == S_EXEC);
      if (ph == S_EXEC) m_ret = (m_ret + 1) % (1 << RW);
      if (cz != 0 && !m_trap) begin m_trap = 1; m_cause = cz; end
      if (brk) m_brk = 1;
      ph = np;
    end
  end

  task automatic tick();
    @(posedge clock);
    #1;
  endtask

  task automatic idle();
    bus.ifu_respValid = 0; bus.ifu_respErr = 0; bus.lsu_respValid = 0; bus.lsu_respErr = 0;
    dec_load = 0; dec_store = 0; dec_branch = 0; dec_ebreak = 0; dec_multi = 0;
    exec_done = 0; halt_req = 0;
  endtask

  task automatic do_reset();
    reset_n = 0;
    idle();
    tick();
    tick();
    reset_n = 1;
  endtask

  initial begin
    idle();
    tick();
    #1 chk("rst_state", state, 0);
    chk("rst_ifu_req", bus.ifu_reqValid, 0);
    chk("rst_retired", retired, 0);
    tick();
    reset_n = 1;
    bus.ifu_respValid = 1;
    #1 chk("start_req", bus.ifu_reqValid, 1);
    tick(); idle();
    #1 chk("stale_ignored", state, S_FETCH);
    tick();
    bus.ifu_respValid = 1;
    #1 chk("alu_pc_wen", pc_wen, 1);
    chk("alu_reg_wen", reg_wen, 1);
    tick(); idle();
    #1 chk("alu_exec", state, S_EXEC);
    chk("alu_fin_early", finished, 0);
    tick();
    #1 chk("alu_fin", finished, 1);
    chk("alu_retired", retired, 1);
    bus.ifu_respValid = 1; dec_store = 1;
    wen_n = 0; pc_n = 0;
    for (int i = 0; i < 6; i++) begin
      if (i == 5) bus.lsu_respValid = 1;
      #1;
      wen_n += int'(bus.lsu_wen);
      pc_n += int'(pc_wen);
      if (i == 0) chk("store_issue_pc_wen", pc_wen, 0);
      tick(); idle();
    end
    chk("store_wen_cycles", wen_n, 5);
    chk("store_pc_wen_cycles", pc_n, 1);
    tick();
    #1 chk("store_retired", retired, 2);
    for (int i = 1; i < TO; i++) tick();
    bus.ifu_respValid = 1; dec_branch = 1;
    #1 chk("late_branch_pc_wen", pc_wen, 1);
    chk("late_branch_reg_wen", reg_wen, 0);
    tick(); idle();
    #1 chk("late_no_trap", trap, 0);
    chk("late_exec", state, S_EXEC);
    tick();
    bus.ifu_respValid = 1; dec_multi = 1;
    #1 chk("mc_start", exec_start, 1);
    tick(); idle();
    es_n = 0;
    for (int i = 1; i <= 10; i++) begin
      if (i == 10) exec_done = 1;
      #1 es_n += int'(exec_start);
      if (i == 10) chk("mc_reg_wen", reg_wen, 1);
      tick(); idle();
    end
    chk("mc_start_once", es_n, 0);
    halt_req = 1;
    #1 chk("halt_no_fetch", bus.ifu_reqValid, 0);
    tick(); idle();
    #1 chk("halt_state", state, S_HALT);
    chk("halt_retired", retired, 4);
    bus.ifu_respValid = 1; bus.lsu_respValid = 1; exec_done = 1;
    #1 chk("halt_quiet", {bus.ifu_reqValid, bus.lsu_reqValid, pc_wen, reg_wen}, 0);
    do_reset();
    tick();
    bus.ifu_respValid = 1; dec_load = 1;
    #1 chk("load_req", bus.lsu_reqValid, 1);
    tick(); idle();
    bus.lsu_respValid = 1; bus.lsu_respErr = 1;
    #1 chk("lderr_wen", {reg_wen, pc_wen}, 0);
    tick(); idle();
    #1 chk("lderr_cause", trap_cause, 2);
    chk("lderr_trap", trap, 1);
    tick();
    #1 chk("lderr_halt", state, S_HALT);
    do_reset();
    tick();
    for (int i = 1; i < TO; i++) tick();
    #1 chk("to_still_fetch", state, S_FETCH);
    tick();
    #1 chk("to_cause", trap_cause, 3);
    tick();
    do_reset();
    tick();
    bus.ifu_respValid = 1; dec_ebreak = 1;
    #1 chk("ebreak_no_pc", pc_wen, 0);
    tick(); idle();
    #1 chk("ebreak_flag", ebreak, 1);
    do_reset();
    tick();
    bus.ifu_respValid = 1; dec_load = 1;
    tick(); idle();
    tick();
    reset_n = 0;
    #1 chk("async_reset", state, S_START);
    tick();
    reset_n = 1;
    bus.lsu_respValid = 1;
    tick();
    bus.ifu_respValid = 1;
    tick(); idle();
    #1 chk("post_reset_exec", state, S_EXEC);
    tick();
    for (int k = 0; k < 16; k++) begin
      bus.ifu_respValid = 1;
      tick(); idle();
      tick();
    end
    #1 chk("retired_wrap", retired, 1);
    for (int n = 0; n < 3000; n++) begin
      tick();
      if (ph == S_HALT || $urandom_range(0, 199) == 0) begin
        reset_n = 0;
        idle();
      end else begin
        reset_n = 1;
        r = int'($urandom_range(0, 19));
        dec_load = r < 3; dec_store = r >= 3 && r < 6; dec_multi = r == 6 || r == 7;
        dec_ebreak = r == 8; dec_branch = r >= 9 && r < 12;
        bus.ifu_respValid = $urandom_range(0, 1) == 1;
        bus.ifu_respErr = $urandom_range(0, 29) == 0;
        bus.lsu_respValid = $urandom_range(0, 1) == 1;
        bus.lsu_respErr = $urandom_range(0, 29) == 0;
        exec_done = $urandom_range(0, 9) < 3;
        halt_req = $urandom_range(0, 19) == 0;
      end
    end
    tick();
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end
endmodule

// File: doc/cpu_ctrl_fsm.md
# cpu_ctrl_fsm

Parametrised multi-cycle CPU control sequencer, the next generation of the SoC's fetch/load/store/exec state machine. It sequences IFU and LSU request/response handshakes and issues register, PC and store write enables per instruction. Beyond the basic fetch/load/store/exec flow it adds:
- error responses that raise a trap
- a programmable memory-wait timeout
- multi-cycle execute-unit support
- debug halt request
- a retired-instruction counter

It sits between the decoder, IFU, LSU, register file and PC register.

## Interface
- TIMEOUT_W, 8: width of memory-wait cycle counter.
- TIMEOUT, 200: memory-wait limit in cycles; 0 disables timeout. Must fit in TIMEOUT_W.
- RETIRE_W, 32: width of retired-instruction counter.

- clock  in  1  system clock, rising edge.
- reset_n  in  1  asynchronous active-low reset.
- ifu_respValid, ifu_respErr  in  1 each  IFU response valid, and error qualifier on it.
- lsu_respValid, lsu_respErr  in  1 each  LSU response valid, and error qualifier on it.
- dec_load, dec_store, dec_branch, dec_ebreak, dec_multi  in  1 each  decoded class of the fetched instruction; at most one set.
- exec_done  in  1  multi-cycle execute unit result ready.
- halt_req  in  1  debug halt request; sampled only in EXEC.
- ifu_reqValid, lsu_reqValid, lsu_wen  out  1 each  memory requests and store qualifier.
- reg_wen, pc_wen, exec_start  out  1 each  combinational strobes.
- finished  out  1  registered one-cycle retire pulse.
- ebreak, trap  out  1 each  sticky flags.
- trap_cause  out  2  1 fetch error, 2 LSU error, 3 timeout, 0 none.
- retired  out  RETIRE_W  count of retired instructions; wraps.
- state  out  3  current state, for debug.

## Operation
- States: START, FETCH, LOAD, STORE, EXEC_MC, EXEC, TRAP, HALT.
- Reset (async, reset_n low):
  - state=START; finished, ebreak, trap, trap_cause, retired, inflight flags, wait counter all 0.
  - All combinational outputs are 0 while reset_n is low.
- Inflight tracking, separate ifu_inflight and lsu_inflight flags:
  - The flag sets on any cycle its reqValid=1.
  - The flag clears on a response while set.
  - A response arriving while the flag is clear is ignored. This covers stale responses after reset.
- START: ifu_reqValid=1 → FETCH.
- FETCH: ifu_reqValid=1 every cycle until an accepted ifu response. On acceptance:
  - err → TRAP with cause 1.
  - dec_load → lsu_reqValid=1 → LOAD.
  - dec_store → lsu_reqValid=1, lsu_wen=1 → STORE.
  - dec_multi → exec_start=1 → EXEC_MC.
  - dec_ebreak → ebreak<=1 → HALT; no reg_wen, no pc_wen.
  - else → reg_wen=!dec_branch, pc_wen=1 → EXEC.
- LOAD: lsu_reqValid=1 while waiting. Accepted response:
  - err → TRAP with cause 2; no reg_wen.
  - else → reg_wen=1, pc_wen=1 → EXEC.
- STORE: lsu_reqValid=1 and lsu_wen=1 while waiting. Accepted response:
  - err → TRAP with cause 2.
  - else → pc_wen=1 → EXEC.
  - pc_wen is asserted only on store completion, never at issue.
- EXEC_MC: waits for exec_done, with no timeout → reg_wen=1, pc_wen=1 → EXEC.
- EXEC: the instruction retires; finished<=1 and retired<=retired+1.
  - halt_req=1 → HALT, with no ifu request.
  - else ifu_reqValid=1 → FETCH.
- TRAP: trap<=1 and trap_cause are latched on entry; one cycle → HALT.
- HALT: terminal; all request and write strobes are 0 until reset.
- Wait counter:
  - Clears on entry to FETCH, LOAD or STORE.
  - Increments each cycle in those states without an accepted response.
  - If TIMEOUT≠0 and counter==TIMEOUT-1 with no accepted response → TRAP with cause 3.
- Sticky: ebreak and trap hold until reset; trap_cause is written only once.

## Timing
- finished is a registered pulse of exactly one cycle: high in the cycle after EXEC. retired updates on the same edge.
- reg_wen, pc_wen, exec_start and lsu_wen are combinational and valid in the cycle the triggering response or state is present.
- Minimum ALU instruction: 2 cycles (FETCH with response, EXEC). Minimum load/store: 3 cycles.
- Same-cycle precedence:
  1. An accepted response beats a timeout on the same cycle.
  2. An error beats the decoded class.
  3. halt_req matters only in EXEC.
- Reset asserted mid-wait: the FSM returns to START and the flags clear. A response for the pre-reset request is then dropped, because its inflight flag is clear.
- The retired counter wraps from all-ones to 0 without any flag.

## Test plan
- Reset, then ALU instruction, ifu response one cycle after the request → pc_wen=1 and reg_wen=1 in FETCH, finished pulse one cycle after EXEC, retired=1.
- Store with lsu response after 5 cycles → lsu_wen held 5 cycles, pc_wen only on the completion cycle, finished once.
- Load with lsu_respErr=1 → no reg_wen or pc_wen, trap=1, trap_cause=2, state HALT, no further requests.
- TIMEOUT=4, IFU never responds → trap after the 4th FETCH wait cycle with cause 3. A second run with the response arriving on cycle 4 → normal retire, no trap.
- ifu_respValid pulse while ifu_inflight=0 (just after reset_n release, before the request) → ignored, FSM stays in FETCH.
- dec_multi with exec_done after 10 cycles → exec_start for one cycle, reg_wen=1 on the exec_done cycle, then halt_req in EXEC → HALT, retired incremented.
